// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package divider_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Iteration counter must be able to hold values up to WIDTH.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_trial_subtract.sv
// Combinational trial subtraction for the restoring divider: diff = a - b, borrow when a < b.
module div_trial_subtract #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    logic [W:0] sum;

    // Two's-complement subtraction; a missing carry-out means the subtraction borrowed.
    assign sum    = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
    assign diff   = sum[W-1:0];
    assign borrow = ~sum[W];

endmodule

// File: rtl/four_bit_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Define FOUR_BIT_DIVIDER_DBZ_EN to short-circuit a zero divisor straight to DONE with a flag.
module four_bit_divider
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] quotient_out,
    output logic [WIDTH-1:0] remainder_out,
    output logic             div_by_zero_out
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t state, state_next;

    logic [WIDTH:0]   rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] div_r;
    logic [CW-1:0]    iter_cnt;

    logic [2*WIDTH:0] shifted;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             last_iter;
    logic             accept;
    logic             zero_div;

    // The top bit of the partial remainder is always zero here, so the shift may drop it.
    assign shifted = {rem_r, quo_r} << 1;

    div_trial_subtract #(
        .W(WIDTH + 1)
    ) u_trial (
        .a      (shifted[2*WIDTH:WIDTH]),
        .b      ({1'b0, div_r}),
        .diff   (trial),
        .borrow (borrow)
    );

    assign rem_next  = borrow ? shifted[2*WIDTH:WIDTH] : trial;
    assign quo_next  = shifted[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, ~borrow};
    assign last_iter = (iter_cnt == CW'(WIDTH - 1));
    assign accept    = start_in && (state != RUN);

`ifdef FOUR_BIT_DIVIDER_DBZ_EN
    assign zero_div = (divisor_in == '0);
`else
    assign zero_div = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start_in) begin
                    state_next = zero_div ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start_in) begin
                    state_next = zero_div ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_out = (state == RUN);
        done_out = (state == DONE);
    end

    // Results are only written on DONE entry and otherwise hold across new starts.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            rem_r         <= '0;
            quo_r         <= '0;
            div_r         <= '0;
            iter_cnt      <= '0;
            quotient_out  <= '0;
            remainder_out <= '0;
        end else if (accept) begin
            rem_r    <= '0;
            quo_r    <= dividend_in;
            div_r    <= divisor_in;
            iter_cnt <= '0;
            if (zero_div) begin
                quotient_out  <= '1;
                remainder_out <= dividend_in;
            end
        end else if (state == RUN) begin
            rem_r    <= rem_next;
            quo_r    <= quo_next;
            iter_cnt <= iter_cnt + CW'(1);
            if (last_iter) begin
                quotient_out  <= quo_next;
                remainder_out <= rem_next[WIDTH-1:0];
            end
        end
    end

`ifdef FOUR_BIT_DIVIDER_DBZ_EN
    logic dbz_r;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            dbz_r <= 1'b0;
        end else if (accept && zero_div) begin
            dbz_r <= 1'b1;
        end else if ((state == RUN) && last_iter) begin
            dbz_r <= 1'b0;
        end
    end

    assign div_by_zero_out = dbz_r;
`else
    assign div_by_zero_out = 1'b0;
`endif

endmodule

// File: tb/tb_four_bit_divider.sv
// Scoreboard bench for four_bit_divider (WIDTH=4); honours FOUR_BIT_DIVIDER_DBZ_EN when defined.
module tb_four_bit_divider;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       dbz;

    typedef struct packed {
        logic [3:0] q;
        logic [3:0] r;
        logic       z;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_done = 1'b0;

    four_bit_divider #(.WIDTH(4)) dut (
        .clk_in          (clk),
        .reset_in        (reset),
        .start_in        (start),
        .dividend_in     (dividend),
        .divisor_in      (divisor),
        .busy_out        (busy),
        .done_out        (done),
        .quotient_out    (quotient),
        .remainder_out   (remainder),
        .div_by_zero_out (dbz)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: every done pulse retires the oldest expected result.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_output("quotient", int'(quotient), int'(e.q));
                check_output("remainder", int'(remainder), int'(e.r));
                check_output("div_by_zero", int'(dbz), int'(e.z));
            end
            check_output("done_twice", int'(prev_done), 0);
        end
        prev_done = done;
    end

    task automatic wait_done(input string name, input int exp_lat, input int exp_busy);
        int  n = 0;
        int  busy_n = 0;
        bit  seen = 0;
        while (n < 20 && !seen) begin
            @(negedge clk);
            n++;
            if (done) seen = 1;
            else if (busy) busy_n++;
        end
        if (!seen) begin
            check_output({name, "_timeout"}, 0, 1);
        end else begin
            check_output({name, "_latency"}, n - 1, exp_lat);
            check_output({name, "_busy_cycles"}, busy_n, exp_busy);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] a, input logic [3:0] b,
                                  input logic [3:0] eq, input logic [3:0] er,
                                  input logic ez, input int exp_lat, input string name);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        exp_q.push_back('{q: eq, r: er, z: ez});
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(name, exp_lat, exp_lat);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int done_seen;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_busy", int'(busy), 0);
        check_output("reset_done", int'(done), 0);
        check_output("reset_quotient", int'(quotient), 0);
        check_output("reset_remainder", int'(remainder), 0);
        check_output("reset_dbz", int'(dbz), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        apply_stimulus(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 4, "div_13_3");
        apply_stimulus(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 4, "div_15_1");
        apply_stimulus(4'd5, 4'd7, 4'd0, 4'd5, 1'b0, 4, "div_5_7");
        apply_stimulus(4'd0, 4'd9, 4'd0, 4'd0, 1'b0, 4, "div_0_9");
        apply_stimulus(4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 4, "div_15_15");
`ifdef FOUR_BIT_DIVIDER_DBZ_EN
        apply_stimulus(4'd9, 4'd0, 4'd15, 4'd9, 1'b1, 0, "div_9_0");
`else
        apply_stimulus(4'd9, 4'd0, 4'd15, 4'd9, 1'b0, 4, "div_9_0");
`endif
        apply_stimulus(4'd14, 4'd4, 4'd3, 4'd2, 1'b0, 4, "div_14_4");

        // Start during RUN is ignored; holding it through DONE launches 6/2 back-to-back.
        start    = 1'b1;
        dividend = 4'd13;
        divisor  = 4'd3;
        exp_q.push_back('{q: 4'd4, r: 4'd1, z: 1'b0});
        @(posedge clk);
        #1;
        dividend = 4'd6;
        divisor  = 4'd2;
        exp_q.push_back('{q: 4'd3, r: 4'd0, z: 1'b0});
        wait_done("ignored_start", 4, 4);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("back_to_back", 4, 4);
        @(posedge clk);
        #1;

        // Reset in the second RUN cycle abandons the operation without a done pulse.
        start    = 1'b1;
        dividend = 4'd13;
        divisor  = 4'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_output("midrun_reset_busy", int'(busy), 0);
        check_output("midrun_reset_done", int'(done), 0);
        check_output("midrun_reset_quotient", int'(quotient), 0);
        check_output("midrun_reset_remainder", int'(remainder), 0);
        check_output("midrun_reset_dbz", int'(dbz), 0);
        done_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check_output("midrun_reset_no_done", done_seen, 0);
        check_output("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
